program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Byte-stream instruction loader: the write side of the instruction RAM. Receives a framed
//  program (length, big-endian 32-bit words, XOR checksum) over a valid/ready byte handshake.
//  Issues one write per word to the instruction RAM, starting at BASE_ADDR.
//  Holds the CPU (cpuHold) until a complete, checksum-correct image is loaded.
// PARAMETERS
//  ADDR_WIDTH  10   width of the instruction RAM address
//  MAX_WORDS   135  largest accepted word count (instruction RAM depth)
//  BASE_ADDR   0    address written by the first word
// PORTS
//  clock      in   1             single clock, all logic on posedge
//  reset      in   1             synchronous, active-high
//  start      in   1             begin a load; sampled only in IDLE, DONE or ERROR
//  byteIn     in   8             incoming byte
//  byteValid  in   1             byteIn is valid
//  byteReady  out  1             loader accepts a byte this cycle
//  wrEnable   out  1             one-cycle instruction RAM write strobe
//  wrAddress  out  ADDR_WIDTH    write address
//  wrData     out  32            write data (instruction word)
//  wordCount  out  ADDR_WIDTH+1  words written in the current load
//  busy       out  1             load in progress
//  done       out  1             last load completed with correct checksum
//  error      out  1             last load aborted (bad length or checksum)
//  cpuHold    out  1             hold CPU; low only in DONE
// BEHAVIOUR
//  Reset (sync, highest priority, any state):
//   - state=IDLE; byteReady=0, wrEnable=0, wrAddress=0, wrData=0, wordCount=0.
//   - busy=0, done=0, error=0, cpuHold=1; byte index, length and checksum cleared.
//  Byte transfer: occurs when byteValid&&byteReady at posedge; byteIn may change freely otherwise.
//  byteReady is a registered state decode: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere.
//  Frame: LEN_HI, LEN_LO (N, 16-bit big-endian), then 4*N data bytes (MSB first per word),
//   then 1 checksum byte = XOR of all 4*N data bytes.
//  FSM transitions:
//   - IDLE/DONE/ERROR -start-> LEN_HI: clear wordCount, checksum, done, error; busy=1, cpuHold=1.
//   - LEN_HI -xfer-> LEN_LO.
//   - LEN_LO -xfer-> DATA if 1<=N<=MAX_WORDS; otherwise ERROR with no writes.
//   - DATA: shift each byte into the assembly register and XOR it into the checksum.
//     On the 4th byte of a word, the next cycle presents wrEnable=1, wrData=word and
//     wrAddress=BASE_ADDR+wordCount, then wordCount increments.
//     Write latency: exactly 1 cycle after the 4th byte transfer.
//     byteReady stays high, so back-to-back bytes sustain 1 byte/cycle.
//     After word N -> CHECK.
//   - CHECK -xfer-> DONE if byte == checksum, else ERROR.
//  Status outputs:
//   - DONE: busy=0, done=1, cpuHold=0.
//   - ERROR: busy=0, error=1, cpuHold=1; words already written stay written.
//   - start while busy is ignored.
//   - DONE/ERROR persist until start or reset.
//  Widths and arithmetic:
//   - wrAddress = (BASE_ADDR + wordCount) truncated to ADDR_WIDTH; wraps silently.
//   - N is compared at full 16 bits, so N=0x0100 with MAX_WORDS=135 -> ERROR.
//  Reset mid-load: abort immediately; no further writes; partial image is left in RAM.
// TESTING
//  1 Nominal: bytes 00 02 6C 00 00 00 54 00 00 51 69, no gaps.
//    -> wrEnable at addr 0 with 0x6C000000, then at addr 1 with 0x54000051.
//    -> done=1, cpuHold=0, wordCount=2.
//  2 Backpressure/gaps: same frame with byteValid toggled randomly.
//    -> identical writes, each exactly 1 cycle after its 4th byte transfer.
//  3 Bad length: 00 00 -> ERROR, no wrEnable, error=1, cpuHold=1.
//    00 88 (136) -> same.
//  4 Bad checksum: frame 1 ending in 68 instead of 69.
//    -> both writes occur, then error=1, done=0, cpuHold=1.
//  5 Reset mid-load: assert reset after the 6th byte.
//    -> next cycle all outputs at reset values, no wrEnable.
//    -> new start + frame 1 loads correctly.
//  6 start pulsed during DATA -> ignored, load completes.
//    start in DONE -> cpuHold=1, done=0, wordCount=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a framed, XOR-checksummed program over a byte handshake
// and writes it word by word into the instruction RAM, holding the CPU until it is complete.
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 135,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  wrEnable,
  output logic [ADDR_WIDTH-1:0] wrAddress,
  output logic [31:0]           wrData,
  output logic [ADDR_WIDTH:0]   wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpuHold
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  xfer;
  logic [15:0]           n;
  logic [31:0]           word;
  logic                  last;
  assign byteReady = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
  assign busy      = byteReady;
  assign done      = state_q == DONE;
  assign error     = state_q == ERROR;
  assign cpuHold   = state_q != DONE;
  assign wrEnable  = wr_en_q;
  assign wrAddress = wr_addr_q;
  assign wrData    = wr_data_q;
  assign wordCount = count_q;
  assign xfer = byteValid && byteReady;
  assign n    = {len_q[15:8], byteIn};
  assign word = {word_q, byteIn};
  assign last = 16'(count_q) + 16'd1 == len_q;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = LEN_HI;
        count_d = '0;
        csum_d  = '0;
        idx_d   = '0;
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = byteIn;
        state_d     = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d   = n;
        state_d = (n != 16'd0 && n <= MAXW) ? DATA : ERROR;
      end
      DATA: if (xfer) begin
        csum_d = csum_q ^ byteIn;
        idx_d  = idx_q + 2'd1;
        word_d = word[23:0];
        if (idx_q == 2'd3) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE + count_q[ADDR_WIDTH-1:0];
          wr_data_d = word;
          count_d   = count_q + (ADDR_WIDTH+1)'(1);
          state_d   = last ? CHECK : DATA;
        end
      end
      CHECK: if (xfer) state_d = byteIn == csum_q ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
    end
  end
endmodule
